gate_bist_checker: RTL and testbench
====================================

# gate_bist_checker

Self-test engine for the NAND-built gate unit (six outputs: AND, OR, NOT, NOR, XOR, XNOR on inputs a, b). It replaces the bench-side stimulus task with synthesizable hardware. On `start` it drives a and b through all four input combinations, waits a settle window, and samples the six gate outputs. Each sample is compared against the golden truth table, and the block reports pass/fail, a mismatch count and the first failing vector, so gate-unit checks can run on the FPGA without a simulator.

## Interface
- `SETTLE_CYCLES`, default 2: clocks between driving a vector and sampling the outputs; legal range 1..15.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset (sampled on `clk` rising edge).
- `start`  in  1  level; sampled only in IDLE; begins one test run.
- `a_o`  out  1  stimulus to gate unit input a.
- `b_o`  out  1  stimulus to gate unit input b.
- `y_and`, `y_or`, `y_not`, `y_nor`, `y_xor`, `y_xnor`  in  1 each  gate unit outputs under test.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 if the last run had zero mismatches; valid from `done`, held until the next accepted start.
- `err_count`  out  3  number of vectors (0..4) with at least one mismatching output.
- `fail_vec`  out  2  {a,b} of the first failing vector; 0 if none.
- `fail_mask`  out  6  per-output mismatch bits of the first failing vector, {and,or,not,nor,xor,xnor} (bit5 = and).

## Operation
- Golden values: and=a&b, or=a|b, not=~a, nor=~(a|b), xor=a^b, xnor=~(a^b).
- Vector order is fixed: {a,b} = 00, 01, 10, 11. A 2-bit index drives `a_o` = idx[1] and `b_o` = idx[0].
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - When `start`=1: idx←0, settle counter←SETTLE_CYCLES−1, err_count←0, fail_vec←0, fail_mask←0, pass←0, busy←1; go to SETTLE.
  - When `start`=0: remain in IDLE.
- SETTLE: counter decrements each clock; when the counter is 0, go to CHECK.
- CHECK: lasts one cycle. Outputs are compared against golden values for the current idx, producing a 6-bit mismatch vector m.
  - If m≠0: err_count increments.
  - If m≠0 and this is the first failure of the run: fail_vec←idx and fail_mask←m.
  - If idx=3: go to DONE.
  - Otherwise: idx increments, the counter reloads to SETTLE_CYCLES−1, and the FSM returns to SETTLE.
- DONE: `done`=1 and `busy`=0 for one cycle; pass←(final err_count==0); return to IDLE.
- `start` during SETTLE, CHECK or DONE is ignored; it is not queued.
- `start` held high continuously causes back-to-back runs, with one IDLE cycle between DONE and the next SETTLE.
- Result registers (`pass`, `err_count`, `fail_vec`, `fail_mask`) hold their values in IDLE until the next accepted start clears them.
- err_count saturates naturally at 4 and never wraps, because there are only four vectors.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE; `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_mask`=0.
- Reset takes priority over every other condition, including mid-run. There is no partial result and no `done` pulse after an aborted run.
- All outputs are registered, with no combinational path from inputs to outputs.
- Edge E0 samples `start`. `a_o`/`b_o` hold vector 0 from E0 onward.
- Each vector occupies SETTLE_CYCLES+1 clocks. `y_*` are sampled at the edge that ends CHECK, after SETTLE_CYCLES full cycles of stable stimulus.
- A vector change takes effect at the same edge that samples the previous vector's CHECK.
- `done` is high for the single cycle following edge E0 + 4·(SETTLE_CYCLES+1). For SETTLE_CYCLES=2 that is edge E12, and `done` falls at E13. `busy` falls at the same edge that `done` rises.
- `a_o`/`b_o` remain at 11 after a run until the next start or reset.

## Test plan
- Correct gate-unit model connected, SETTLE_CYCLES=2, pulse `start` → `done` exactly 12 clocks after the start edge; pass=1, err_count=0, fail_vec=00, fail_mask=000000.
- `y_xor` forced to 0 → mismatches at 01 and 10; err_count=2, fail_vec=01, fail_mask=000010, pass=0.
- `y_not` wired to b instead of ~a → vectors 00 and 11 fail (01 and 10 match); err_count=2, fail_vec=00, fail_mask=001000.
- `start` re-pulsed at clocks 3 and 7 of a run → ignored; `done` still at clock 12. The run that follows with `start` held high shows one IDLE cycle, then `busy` reasserts and the results are cleared.
- `rst_n` asserted at clock 5 of a run → next cycle: all outputs are at reset values, no `done` pulse; a fresh start afterwards completes normally.
- SETTLE_CYCLES=1 build → `done` 8 clocks after start. Each vector is held exactly 2 clocks, verified by monitoring `a_o`/`b_o` transitions.

Source files
------------

// File: rtl/gate_bist_checker_if.sv
// Handshake and probe bundle between the gate-unit self-test engine and
// the gate unit under test (plus whoever launches runs and reads results).
interface gate_bist_checker_if;
  logic       start;
  logic       a_o;
  logic       b_o;
  logic       y_and;
  logic       y_or;
  logic       y_not;
  logic       y_nor;
  logic       y_xor;
  logic       y_xnor;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  logic [5:0] fail_mask;

  // Checker side: drives stimulus and results, observes gate outputs.
  modport master (
    input  start, y_and, y_or, y_not, y_nor, y_xor, y_xnor,
    output a_o, b_o, busy, done, pass, err_count, fail_vec, fail_mask
  );

  // Environment side: launches runs, supplies gate outputs, reads results.
  modport slave (
    output start, y_and, y_or, y_not, y_nor, y_xor, y_xnor,
    input  a_o, b_o, busy, done, pass, err_count, fail_vec, fail_mask
  );
endinterface

// File: rtl/gate_bist_checker.sv
// Built-in self-test engine for the six-output gate unit. Walks {a,b}
// through 00,01,10,11, lets each vector settle, samples the gate outputs,
// and records pass/fail, mismatch count and the first failing vector.
module gate_bist_checker #(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input logic             clk,
  input logic             rst_n,
  gate_bist_checker_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nx;
  logic [1:0] idx, idx_nx;
  logic [3:0] cnt, cnt_nx;
  logic       busy, busy_nx;
  logic       done, done_nx;
  logic       pass, pass_nx;
  logic [2:0] err_count, err_count_nx;
  logic [1:0] fail_vec, fail_vec_nx;
  logic [5:0] fail_mask, fail_mask_nx;

  logic [5:0] golden;
  logic [5:0] observed;
  logic [5:0] mismatch;

  // Golden truth table for the vector currently driven, bit5 = and.
  always_comb begin
    golden   = {idx[1] & idx[0], idx[1] | idx[0], ~idx[1],
                ~(idx[1] | idx[0]), idx[1] ^ idx[0], ~(idx[1] ^ idx[0])};
    observed = {bus.y_and, bus.y_or, bus.y_not, bus.y_nor, bus.y_xor, bus.y_xnor};
    mismatch = observed ^ golden;
  end

  // Next-state and next-result logic for the run sequencer.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case leaves it unassigned; without this a latch would be inferred.
    state_nx     = state;
    idx_nx       = idx;
    cnt_nx       = cnt;
    busy_nx      = busy;
    done_nx      = 1'b0;
    pass_nx      = pass;
    err_count_nx = err_count;
    fail_vec_nx  = fail_vec;
    fail_mask_nx = fail_mask;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx     = SETTLE;
          idx_nx       = 2'd0;
          cnt_nx       = RELOAD;
          err_count_nx = 3'd0;
          fail_vec_nx  = 2'd0;
          fail_mask_nx = 6'd0;
          pass_nx      = 1'b0;
          busy_nx      = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_nx = CHECK;
        else             cnt_nx   = cnt - 4'd1;
      end
      CHECK: begin
        if (mismatch != 6'd0) begin
          err_count_nx = err_count + 3'd1;
          // An empty count means this is the first failure of the run.
          if (err_count == 3'd0) begin
            fail_vec_nx  = idx;
            fail_mask_nx = mismatch;
          end
        end
        if (idx == 2'd3) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          // Make pass valid in the same cycle done is seen.
          pass_nx  = (err_count_nx == 3'd0);
        end else begin
          state_nx = SETTLE;
          idx_nx   = idx + 2'd1;
          cnt_nx   = RELOAD;
        end
      end
      DONE: begin
        state_nx = IDLE;
        pass_nx  = (err_count == 3'd0);
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and result registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 2'd0;
      fail_mask <= 6'd0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      err_count <= err_count_nx;
      fail_vec  <= fail_vec_nx;
      fail_mask <= fail_mask_nx;
    end
  end

  // Stimulus comes straight from the vector index register.
  assign bus.a_o       = idx[1];
  assign bus.b_o       = idx[0];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.fail_vec  = fail_vec;
  assign bus.fail_mask = fail_mask;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: two builds (SETTLE_CYCLES=2 and 1) share
// start/reset and each drives its own copy of a configurable gate unit.
// A timeline-based model predicts every output on every cycle.
module tb_gate_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  int   mode;                 // 0 good, 1 xor stuck 0, 2 not=b, 3 random flips
  logic [3:0][5:0] flip;      // per-vector output inversions for mode 3

  int total = 0;
  int bad   = 0;

  gate_bist_checker_if bus2();
  gate_bist_checker_if bus1();

  gate_bist_checker #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));
  gate_bist_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  // Truth table from the gate definitions, bit5 = and.
  function automatic logic [5:0] golden(input logic [1:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {a & b, a | b, ~a, ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  // Gate unit under test with optional planted defects.
  function automatic logic [5:0] gate_unit(input logic [1:0] v, input int md,
                                           input logic [3:0][5:0] fl);
    logic [5:0] g;
    g = golden(v);
    case (md)
      1: g[1] = 1'b0;
      2: g[3] = v[0];
      3: g = g ^ fl[v];
      default: ;
    endcase
    return g;
  endfunction

  logic [5:0] y2, y1;
  always_comb begin
    y2 = gate_unit({bus2.a_o, bus2.b_o}, mode, flip);
    y1 = gate_unit({bus1.a_o, bus1.b_o}, mode, flip);
  end
  assign {bus2.y_and, bus2.y_or, bus2.y_not, bus2.y_nor, bus2.y_xor, bus2.y_xnor} = y2;
  assign {bus1.y_and, bus1.y_or, bus1.y_not, bus1.y_nor, bus1.y_xor, bus1.y_xnor} = y1;
  assign bus2.start = start;
  assign bus1.start = start;

  // ---------------- behavioural model (index 0: S=2, index 1: S=1) -------
  int         m_settle [2] = '{2, 1};
  bit         model_valid = 1'b0;
  bit         m_active [2];
  int         m_k      [2];
  logic [1:0] e_ab     [2];
  logic       e_busy   [2];
  logic       e_done   [2];
  logic       e_pass   [2];
  logic [2:0] e_err    [2];
  logic [1:0] e_vec    [2];
  logic [5:0] e_mask   [2];

  // m_k counts edges since the accepted start; a vector is sampled at every
  // multiple of (S+1), and the run ends at 4*(S+1).
  always @(posedge clk) begin
    if (!rst_n) begin
      model_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 1'b0; m_k[i] = 0;
        e_ab[i] = 2'd0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_pass[i] = 1'b0;
        e_err[i] = 3'd0; e_vec[i] = 2'd0; e_mask[i] = 6'd0;
      end
    end else if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        int per, len, v;
        logic [5:0] mm;
        per = m_settle[i] + 1;
        len = 4 * per;
        if (m_active[i]) begin
          m_k[i]++;
          e_done[i] = 1'b0;
          if (m_k[i] > len) begin
            m_active[i] = 1'b0;
          end else begin
            if (m_k[i] % per == 0) begin
              v  = m_k[i] / per - 1;
              mm = gate_unit(2'(v), mode, flip) ^ golden(2'(v));
              if (mm != 6'd0) begin
                if (e_err[i] == 3'd0) begin
                  e_vec[i]  = 2'(v);
                  e_mask[i] = mm;
                end
                e_err[i] = e_err[i] + 3'd1;
              end
            end
            if (m_k[i] == len) begin
              e_done[i] = 1'b1;
              e_busy[i] = 1'b0;
              e_pass[i] = (e_err[i] == 3'd0);
            end else begin
              e_ab[i] = 2'(m_k[i] / per);
            end
          end
        end else if (start) begin
          m_active[i] = 1'b1; m_k[i] = 0;
          e_ab[i] = 2'd0; e_busy[i] = 1'b1; e_pass[i] = 1'b0;
          e_err[i] = 3'd0; e_vec[i] = 2'd0; e_mask[i] = 6'd0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_dut(input int i, input logic [1:0] ab, input logic bsy,
                             input logic dn, input logic ps, input logic [2:0] er,
                             input logic [1:0] fv, input logic [5:0] fm);
    check($sformatf("dut%0d_ab", i),        8'(ab),  8'(e_ab[i]));
    check($sformatf("dut%0d_busy", i),      8'(bsy), 8'(e_busy[i]));
    check($sformatf("dut%0d_done", i),      8'(dn),  8'(e_done[i]));
    check($sformatf("dut%0d_pass", i),      8'(ps),  8'(e_pass[i]));
    check($sformatf("dut%0d_err_count", i), 8'(er),  8'(e_err[i]));
    check($sformatf("dut%0d_fail_vec", i),  8'(fv),  8'(e_vec[i]));
    check($sformatf("dut%0d_fail_mask", i), 8'(fm),  8'(e_mask[i]));
  endtask

  // Per-cycle compare against the model, plus a hold-length monitor on the
  // S=1 build's stimulus (every vector must last exactly 2 clocks).
  logic       prev_busy1 = 1'b0;
  logic [1:0] last_ab1;
  int         hold1 = 0;
  always @(negedge clk) begin
    if (model_valid) begin
      compare_dut(0, {bus2.a_o, bus2.b_o}, bus2.busy, bus2.done, bus2.pass,
                  bus2.err_count, bus2.fail_vec, bus2.fail_mask);
      compare_dut(1, {bus1.a_o, bus1.b_o}, bus1.busy, bus1.done, bus1.pass,
                  bus1.err_count, bus1.fail_vec, bus1.fail_mask);
      if (bus1.busy === 1'b1 && !prev_busy1) begin
        hold1    = 1;
        last_ab1 = {bus1.a_o, bus1.b_o};
      end else if (bus1.busy === 1'b1) begin
        if ({bus1.a_o, bus1.b_o} != last_ab1) begin
          check("s1_hold", 8'(hold1), 8'd2);
          hold1    = 1;
          last_ab1 = {bus1.a_o, bus1.b_o};
        end else begin
          hold1++;
        end
      end else if (prev_busy1 && bus1.done === 1'b1) begin
        check("s1_hold_last", 8'(hold1), 8'd2);
      end
      prev_busy1 = (bus1.busy === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge and measure edges to done for both builds.
  task automatic run_pulse(output int lat2, output int lat1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat2 = -1;
    lat1 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus1.done === 1'b1 && lat1 < 0) lat1 = n;
      if (bus2.done === 1'b1 && lat2 < 0) lat2 = n;
      if (lat2 >= 0 && lat1 >= 0) break;
    end
  endtask

  initial begin
    int l2, l1;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    flip  = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Good gate unit.
    run_pulse(l2, l1);
    check("lat_s2", 8'(l2), 8'd12);
    check("lat_s1", 8'(l1), 8'd8);
    check("good_pass", 8'(bus2.pass), 8'd1);
    check("good_err", 8'(bus2.err_count), 8'd0);
    check("good_mask", 8'(bus2.fail_mask), 8'd0);
    tick(2);

    // xor stuck at 0.
    mode = 1;
    run_pulse(l2, l1);
    check("xor_err", 8'(bus2.err_count), 8'd2);
    check("xor_vec", 8'(bus2.fail_vec), 8'd1);
    check("xor_mask", 8'(bus2.fail_mask), 8'b000010);
    check("xor_pass", 8'(bus2.pass), 8'd0);
    tick(2);

    // not wired to b.
    mode = 2;
    run_pulse(l2, l1);
    check("not_err", 8'(bus2.err_count), 8'd2);
    check("not_vec", 8'(bus2.fail_vec), 8'd0);
    check("not_mask", 8'(bus2.fail_mask), 8'b001000);
    tick(2);

    // start re-pulsed at clocks 3 and 7, then held for back-to-back runs.
    mode = 0;
    start = 1'b1;
    tick(1);
    for (int c = 1; c <= 12; c++) begin
      start = (c == 3 || c == 7);
      tick(1);
    end
    check("repulse_done12", 8'(bus2.done), 8'd1);
    start = 1'b1;
    tick(1);
    check("b2b_idle_busy", 8'(bus2.busy), 8'd0);
    check("b2b_idle_pass", 8'(bus2.pass), 8'd1);
    tick(1);
    check("b2b_rebusy", 8'(bus2.busy), 8'd1);
    check("b2b_cleared", 8'(bus2.pass), 8'd0);
    tick(30);
    start = 1'b0;
    tick(16);

    // Reset at clock 5 of a run.
    mode = 3;
    for (int v = 0; v < 4; v++) flip[v] = 6'($urandom);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rst_busy", 8'(bus2.busy), 8'd0);
    check("rst_done", 8'(bus2.done), 8'd0);
    check("rst_ab", 8'({bus2.a_o, bus2.b_o}), 8'd0);
    check("rst_err", 8'(bus2.err_count), 8'd0);
    tick(14);
    mode = 0;
    run_pulse(l2, l1);
    check("after_rst_lat", 8'(l2), 8'd12);
    check("after_rst_pass", 8'(bus2.pass), 8'd1);
    tick(2);

    // Random traffic: start, occasional reset and fault changes.
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) begin
        mode = $urandom_range(0, 3);
        for (int v = 0; v < 4; v++)
          flip[v] = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      end
      tick(1);
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
